// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding and the access legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Unsigned sizes exist for loads only; H/W need natural alignment.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~offset[0];
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// sub-word merge of store data into an existing memory word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] merge_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        store_word = merge_word;
        case (funct3)
            F3_B: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1]) store_word[31:16] = wdata[15:0];
                else           store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/halfword/word requests onto a word-only memory,
// using read-modify-write for sub-word stores and faulting illegal accesses.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory read (loads, SB/SH) or direct write (SW)
// WRITE  | write back merged word for SB/SH
// RESP   | done pulse, fault valid
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    lsu_state_e        state, state_nxt;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic              fault_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign ready     = (state == ST_IDLE);
    assign done      = (state == ST_RESP);
    assign fault     = done & fault_q;

    lsu_lane u_lane (
        .rd_word    (mem_rd),
        .merge_word (merge_q),
        .offset     (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        case (state)
            ST_IDLE: begin
                if (req)
                    state_nxt = access_legal(is_store, funct3, addr[1:0]) ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                mem_a = word_addr;
                if (is_store_q && funct3_q == F3_W) begin
                    mem_we    = 1'b1;
                    mem_wd    = wdata_q;
                    state_nxt = ST_RESP;
                end else if (is_store_q) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            ST_WRITE: begin
                mem_a     = word_addr;
                mem_we    = 1'b1;
                mem_wd    = store_word;
                state_nxt = ST_RESP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            fault_q    <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        fault_q    <= ~access_legal(is_store, funct3, addr[1:0]);
                    end
                end
                ST_ACCESS: begin
                    if (is_store_q) merge_q <= mem_rd;
                    else            rdata   <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array memory model, directed
// cases plus a randomized stream checked against an arithmetic reference.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .ready(ready), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .done(done), .rdata(rdata),
        .fault(fault), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem      [64];
    logic [31:0] init_mem [64];
    logic [31:0] ref_mem  [64];
    logic        load_en;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc_cyc;
        int          done_cyc;
        int          we;
    } exp_t;

    exp_t        sbq[$];
    int          compared = 0;
    int          failed = 0;
    int          accepts = 0;
    int          aborted = 0;
    int          done_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: expected response from the size/sign rules applied to ref_mem.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        int          off;
        logic        legal;
        logic [31:0] w, v, mask;
        int          sh;
        off = int'(a[1:0]);
        case (f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = (off % 2) == 0;
            3'b010:  legal = off == 0;
            3'b100:  legal = !st;
            3'b101:  legal = !st && (off % 2) == 0;
            default: legal = 1'b0;
        endcase
        w = ref_mem[a[7:2]];
        e.fault = !legal;
        e.we = 0;
        if (!legal) begin
            e.done_cyc = 0;
        end else if (!st) begin
            e.done_cyc = 1;
            if (f3 == 3'b000 || f3 == 3'b100) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end else if (f3 == 3'b001 || f3 == 3'b101) begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end else begin
                v = w;
            end
            last_rdata = v;
        end else begin
            e.we = 1;
            e.done_cyc = (f3 == 3'b010) ? 1 : 2;
            if (f3 == 3'b000)      begin mask = 32'hFF;   sh = 8 * off; end
            else if (f3 == 3'b001) begin mask = 32'hFFFF; sh = 16 * (off / 2); end
            else                   begin mask = 32'hFFFF_FFFF; sh = 0; end
            ref_mem[a[7:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end
        e.rdata = last_rdata;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic keep,
                          input logic use_want, input logic [31:0] want);
        exp_t e;
        int   t;
        @(negedge clk);
        req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        t = 0;
        while (!ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", {31'h0, ready}, 32'h1);
        if (!ready) begin
            req = 1'b0;
            return;
        end
        model(st, f3, a, wd, e);
        if (use_want) e.rdata = want;
        e.acc_cyc  = cyc + 1;
        e.done_cyc = e.done_cyc + cyc + 1;
        sbq.push_back(e);
        accepts++;
        @(posedge clk);
        #1;
        if (!keep) req = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() > 0 || !ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sbq.size(), 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            we_cnt = 0;
        end else begin
            if (mem_we) we_cnt++;
            chk("mem_a_align", {30'h0, mem_a[1:0]}, 32'h0);
            if (done) begin
                done_cnt++;
                chk("done_expected", {31'h0, sbq.size() > 0}, 32'h1);
                chk("ready_at_done", {31'h0, ready}, 32'h0);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("rdata", rdata, e.rdata);
                    chk("fault", {31'h0, fault}, {31'h0, e.fault});
                    chk("we_pulses", we_cnt, e.we);
                end
                we_cnt = 0;
            end else if (sbq.size() > 0 && cyc >= sbq[0].acc_cyc) begin
                chk("ready_busy", {31'h0, ready}, 32'h0);
                chk("done_late", {31'h0, cyc > sbq[0].done_cyc}, 32'h0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        logic [2:0]  f3s[8];
        int          k;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        reset = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[16] = 32'h8000_80F0;
        init_mem[4]  = 32'h1122_3344;
        init_mem[12] = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        load_en = 1'b0;
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;

        do_req(1'b0, 3'b000, 32'h40, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0); drain();
        do_req(1'b0, 3'b100, 32'h43, 32'h0, 1'b0, 1'b1, 32'h0000_0080); drain();
        do_req(1'b0, 3'b001, 32'h42, 32'h0, 1'b0, 1'b1, 32'hFFFF_8000); drain();
        do_req(1'b0, 3'b101, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0000_80F0); drain();

        do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b0, 1'b0, 32'h0); drain();
        chk("sb_word", mem[4], 32'h1122_AB44);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0); drain();
        chk("sh_word", mem[4], 32'hBEEF_AB44);

        do_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0); drain();
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF); drain();

        do_req(1'b0, 3'b010, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0); drain();
        do_req(1'b1, 3'b001, 32'h13, 32'h1234_5678, 1'b0, 1'b0, 32'h0); drain();
        do_req(1'b1, 3'b100, 32'h14, 32'h1234_5678, 1'b0, 1'b0, 32'h0); drain();
        chk("fault_word4", mem[4], 32'hBEEF_AB44);
        chk("fault_word5", mem[5], ref_mem[5]);

        // Abort an SB in its WRITE cycle with reset.
        saved = ref_mem[12];
        do_req(1'b1, 3'b000, 32'h30, 32'h0000_005A, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("write_phase_we", {31'h0, mem_we}, 32'h1);
        reset = 1'b1;
        sbq.delete();
        aborted++;
        ref_mem[12] = saved;
        last_rdata = 32'h0;
        #1;
        chk("abort_we_drop", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'h0, ready}, 32'h1);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_word", mem[12], 32'h0);

        for (int n = 0; n < 80; n++) begin
            k = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
            do_req(1'($urandom_range(0, 1)), f3s[k], 32'($urandom_range(0, 255)),
                   $urandom, (n != 79), 1'b0, 32'h0);
        end
        drain();
        chk("done_vs_accept", done_cnt, accepts - aborted);
        for (int i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
